seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Purpose  : Multiplexed seven-segment scan controller. Values are loaded
//            through a valid/ready handshake and committed only at frame
//            boundaries. Optional leading-zero blanking: SEVEN_SEG_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int              CNT_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic       xfer;
  logic [3:0] nib;
  logic       blank;
  logic       zero_above;

  assign load_ready_o = rst && !pend_valid_q;
  assign xfer         = load_valid_i && load_ready_o;

  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    frame_end    = tick && (idx_q == IDX_MAX);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    nib          = 4'd0;
    blank        = 1'b0;
    zero_above   = 1'b1;

    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    // Commit and accept are exclusive: commit needs pending set, accept needs it clear.
    if (frame_end && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end else if (xfer) begin
      pend_d       = load_data_i;
      pend_valid_d = 1'b1;
    end

    // Decode from next-state so seg/an line up with the index right after a tick.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) nib = disp_d[4*i +: 4];
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_d[4*i +: 4] == 4'd0);
      if ((idx_d == IDX_W'(i)) && (i != 0)) blank = zero_above;
    end
`else
    blank      = 1'b0;
    zero_above = 1'b0;
`endif

    seg_d = blank ? SEG_BLANK : seg_decode(nib);
    an_d  = ~(NUM_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_end && rst;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Purpose  : Scoreboard bench for seven_seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .PRESCALE   (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .load_data_i  (load_data),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .seg_o        (seg),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;

  // Reference state: m_t counts cycles since the last reset edge.
  int          m_t     = 0;
  logic [15:0] m_disp  = '0;
  logic [15:0] m_pend  = '0;
  logic        m_pv    = 1'b0;
  logic        m_rstd  = 1'b1;
  logic        m_acc   = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input logic [15:0] disp, input int i);
    logic [15:0] sh;
    sh = disp >> (4 * i);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (i != 0 && sh == 16'd0) return 7'b1111111;
`endif
    return ref_seg(sh[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model the edge from the inputs held this cycle, push the
  // expected outputs, then pop and compare against the DUT just after the edge.
  task automatic cyc();
    logic        rst_p;
    logic        v_p;
    logic [15:0] d_p;
    logic        fd_p;
    logic        rdy_p;
    int          idx;
    exp_t        e;
    exp_t        o;
    rst_p = rst;
    v_p   = load_valid;
    d_p   = load_data;
    fd_p  = (m_t % 16 == 15);
    rdy_p = rst_p && !m_pv;
    @(posedge clk);
    m_acc = 1'b0;
    if (!rst_p) begin
      m_t    = 0;
      m_disp = '0;
      m_pend = '0;
      m_pv   = 1'b0;
      m_rstd = 1'b1;
    end else begin
      if (fd_p && m_pv) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end else if (v_p && rdy_p) begin
        m_pend = d_p;
        m_pv   = 1'b1;
        m_acc  = 1'b1;
      end
      m_t++;
      m_rstd = 1'b0;
    end
    idx   = (m_t / 4) % 4;
    e.fd  = (m_t % 16 == 15) && rst_p;
    e.rdy = rst_p && !m_pv;
    e.an  = m_rstd ? 4'b1111 : ~(4'b0001 << idx);
    e.seg = m_rstd ? 7'b1111111 : ref_digit(m_disp, idx);
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    chk("seg",        32'(seg),        32'(o.seg));
    chk("an",         32'(an),         32'(o.an));
    chk("frame_done", 32'(frame_done), 32'(o.fd));
    chk("load_ready", 32'(load_ready), 32'(o.rdy));
  endtask

  task automatic load_one(input logic [15:0] d);
    load_data  = d;
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (m_acc) break;
    end
    if (!m_acc) begin
      n_total++;
      n_bad++;
      $display("FAIL load_timeout value=%0h not accepted within 100 cycles", d);
    end
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'hFFFF;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (40) cyc();

    // Mid-frame load of 0x1298, then watch the commit at the boundary.
    repeat (5) cyc();
    load_one(16'h1298);
    repeat (40) cyc();

    // Producer holds valid across frames; second value waits for the first commit.
    load_data  = 16'h1111;
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (m_acc) break;
    end
    load_data = 16'h2222;
    repeat (60) cyc();
    load_valid = 1'b0;
    repeat (20) cyc();

    // Non-BCD nibble at digit 2.
    load_one(16'h0A00);
    repeat (40) cyc();

    // Leading-zero patterns.
    load_one(16'h0050);
    repeat (40) cyc();
    load_one(16'h0000);
    repeat (40) cyc();

    // Reset mid-frame with a value pending.
    repeat (3) cyc();
    load_one(16'h4321);
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    repeat (40) cyc();

    for (int r = 0; r < 4; r++) begin
      load_one(16'($urandom));
      repeat ($urandom_range(0, 20)) cyc();
    end
    repeat (40) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
